mux2_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a WIDTH-bit 2:1 mux and shares one downstream channel between requester 0 and requester 1. It grants the channel for one packet at a time, with a fairness limit of MAX_BURST beats per grant. It sits between two data sources and a single consumer with a valid/ready handshake.

---
 rtl/mux2_arbiter_pkg.sv | 20 ++
 rtl/mux2_word.sv | 19 +
 rtl/mux2_arbiter.sv | 121 ++++++++++++
 tb/tb_mux2_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding and the burst-counter width.
package mux2_arbiter_pkg;

  // Arbiter states; GRANT0/GRANT1 name the requester that owns the channel.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  // Burst counter must hold 0..MAX_BURST; clamp to 1 bit for degenerate values.
  function automatic int cnt_width(input int max_burst);
    if (max_burst < 1) begin
      return 1;
    end
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux2_word.sv
// WIDTH-bit 2:1 multiplexer: y = a when sel=0, b when sel=1.
module mux2_word #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // One select per bit, all sharing the same sel line.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = sel ? b[gi] : a[gi];
    end
  endgenerate

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 data mux.
// One requester owns the channel at a time; a grant ends on packet end,
// on reaching MAX_BURST beats, or when the owner drops its request.
module mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             last0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  input  logic             last1,
  output logic             gnt1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  import mux2_arbiter_pkg::*;

  localparam int             CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_BURST - 1);

  state_t        state_reg, state_next, other_state;
  logic          ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          gnt0_reg, gnt1_reg, sel_reg;

  logic granted, cur_req, cur_last, other_req;
  logic beat, pkt_done, burst_done, grant_end;

  // Next-state, tie pointer and burst counter decisions for this edge.
  always_comb begin
    granted     = (state_reg == GRANT0) || (state_reg == GRANT1);
    cur_req     = (state_reg == GRANT1) ? req1  : req0;
    cur_last    = (state_reg == GRANT1) ? last1 : last0;
    other_req   = (state_reg == GRANT1) ? req0  : req1;
    other_state = (state_reg == GRANT1) ? GRANT0 : GRANT1;

    beat       = granted && cur_req && y_ready;
    pkt_done   = beat && cur_last;
    burst_done = beat && (cnt_reg == LAST_CNT);
    grant_end  = granted && (!cur_req || pkt_done || burst_done);

    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req0 && (!req1 || !ptr_reg)) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (grant_end) begin
          // The other requester gets priority on the next tie.
          ptr_next = (state_reg == GRANT0);
          cnt_next = '0;
          if (other_req) begin
            state_next = other_state;
          end else if (cur_req && !pkt_done) begin
            // Burst cut short with nobody waiting: keep going on a fresh burst.
            state_next = state_reg;
          end else begin
            // Packet finished (or abandoned) and nobody else waiting.
            state_next = IDLE;
          end
        end else if (beat) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, pointer, counter and the registered grant/select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      cnt_reg   <= '0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt0_reg  <= (state_next == GRANT0);
      gnt1_reg  <= (state_next == GRANT1);
      sel_reg   <= (state_next == GRANT1);
    end
  end

  assign gnt0    = gnt0_reg;
  assign gnt1    = gnt1_reg;
  assign sel     = sel_reg;
  assign y_valid = (gnt0_reg && req0) || (gnt1_reg && req1);

  mux2_word #(
    .WIDTH(WIDTH)
  ) u_y_mux (
    .sel(sel_reg),
    .a  (d0),
    .b  (d1),
    .y  (y)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter (WIDTH=8, MAX_BURST=4).
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, last0, gnt0;
  logic       req1, last1, gnt1;
  logic [7:0] d0, d1, y;
  logic       y_valid, y_ready, sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(
    .WIDTH(8),
    .MAX_BURST(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .d0     (d0),
    .last0  (last0),
    .gnt0   (gnt0),
    .req1   (req1),
    .d1     (d1),
    .last1  (last1),
    .gnt1   (gnt1),
    .y      (y),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .sel    (sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic g0, input logic g1, input logic s);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(g0));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(g1));
    chk({tag, "_sel"},  32'(sel),  32'(s));
  endtask

  task automatic chk_y(input string tag, input logic v, input logic [7:0] data);
    $display("[%0t] %s: gnt0=%b gnt1=%b sel=%b y_valid=%b y=%02h y_ready=%b",
             $time, tag, gnt0, gnt1, sel, y_valid, y, y_ready);
    chk({tag, "_y_valid"}, 32'(y_valid), 32'(v));
    if (v) begin
      chk({tag, "_y"}, 32'(y), 32'(data));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; last0 = 0; last1 = 0;
    d0 = 8'h00; d1 = 8'h00; y_ready = 1'b0;
    #1;
    chk_grant("por", 1'b0, 1'b0, 1'b0);
    chk("por_ptr", 32'(dut.ptr_reg), 32'd0);
    chk("por_cnt", 32'(dut.cnt_reg), 32'd0);
    chk_y("por", 1'b0, 8'h00);
    tick(); tick();
    rst = 1'b0;

    // Single requester, 3-beat packet.
    req0 = 1; d0 = 8'hA0; y_ready = 1; settle();
    chk_grant("s_idle", 1'b0, 1'b0, 1'b0);
    chk_y("s_idle", 1'b0, 8'h00);
    tick();
    chk_grant("s_c1", 1'b1, 1'b0, 1'b0);
    chk("s_c1_cnt", 32'(dut.cnt_reg), 32'd0);
    settle(); chk_y("s_beat1", 1'b1, 8'hA0);
    tick();
    chk("s_c2_cnt", 32'(dut.cnt_reg), 32'd1);
    d0 = 8'hA1; settle(); chk_y("s_beat2", 1'b1, 8'hA1);
    tick();
    chk("s_c3_cnt", 32'(dut.cnt_reg), 32'd2);
    d0 = 8'hA2; last0 = 1; settle(); chk_y("s_beat3", 1'b1, 8'hA2);
    tick();
    chk_grant("s_c4", 1'b0, 1'b0, 1'b0);
    chk("s_c4_state", 32'(dut.state_reg), 32'd0);
    chk("s_c4_ptr", 32'(dut.ptr_reg), 32'd1);
    req0 = 0; last0 = 0; settle(); chk_y("s_c4", 1'b0, 8'h00);

    // Asynchronous reset during a grant (ptr=1 so requester 1 wins the tie).
    req0 = 1; req1 = 1; d0 = 8'hB0; d1 = 8'hC0; settle();
    tick();
    chk_grant("r_pre", 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_grant("r_async", 1'b0, 1'b0, 1'b0);
    chk("r_async_ptr", 32'(dut.ptr_reg), 32'd0);
    chk("r_async_cnt", 32'(dut.cnt_reg), 32'd0);
    chk_y("r_async", 1'b0, 8'hB0);
    tick();
    rst = 1'b0; settle();

    // Tie after reset: 2-beat packets, alternate with no bubble.
    tick();
    chk_grant("t_g0", 1'b1, 1'b0, 1'b0);
    chk("t_g0_ptr", 32'(dut.ptr_reg), 32'd0);
    settle(); chk_y("t_b0", 1'b1, 8'hB0);
    tick();
    chk("t_g0_cnt", 32'(dut.cnt_reg), 32'd1);
    d0 = 8'hB1; last0 = 1; settle(); chk_y("t_b1", 1'b1, 8'hB1);
    tick();
    chk_grant("t_g1", 1'b0, 1'b1, 1'b1);
    chk("t_g1_ptr", 32'(dut.ptr_reg), 32'd1);
    chk("t_g1_cnt", 32'(dut.cnt_reg), 32'd0);
    d0 = 8'hB2; last0 = 0; settle(); chk_y("t_c0", 1'b1, 8'hC0);
    tick();
    chk_grant("t_g1b", 1'b0, 1'b1, 1'b1);
    d1 = 8'hC1; last1 = 1; settle(); chk_y("t_c1", 1'b1, 8'hC1);
    tick();
    chk_grant("t_regrant", 1'b1, 1'b0, 1'b0);
    chk("t_regrant_ptr", 32'(dut.ptr_reg), 32'd0);
    req1 = 0; last1 = 0; last0 = 1; settle(); chk_y("t_b2", 1'b1, 8'hB2);
    tick();
    chk_grant("t_end", 1'b0, 1'b0, 1'b0);
    chk("t_end_ptr", 32'(dut.ptr_reg), 32'd1);
    req0 = 0; last0 = 0; settle(); chk_y("t_end", 1'b0, 8'h00);

    // Fairness: 6-beat packet from 0 cut at 4 beats, 2-beat packet from 1, stall in GRANT1.
    req0 = 1; d0 = 8'h10; settle();
    tick();
    chk_grant("f_g0", 1'b1, 1'b0, 1'b0);
    req1 = 1; d1 = 8'h20; settle(); chk_y("f_d0_0", 1'b1, 8'h10);
    tick(); d0 = 8'h11; settle(); chk_y("f_d0_1", 1'b1, 8'h11);
    tick(); d0 = 8'h12; settle(); chk_y("f_d0_2", 1'b1, 8'h12);
    tick();
    chk("f_cnt3", 32'(dut.cnt_reg), 32'd3);
    d0 = 8'h13; settle(); chk_y("f_d0_3", 1'b1, 8'h13);
    tick();
    chk_grant("f_g1", 1'b0, 1'b1, 1'b1);
    chk("f_g1_cnt", 32'(dut.cnt_reg), 32'd0);
    d0 = 8'h14; y_ready = 0; settle(); chk_y("f_stall0", 1'b1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant("f_stall", 1'b0, 1'b1, 1'b1);
      chk("f_stall_cnt", 32'(dut.cnt_reg), 32'd0);
      settle(); chk_y("f_stall", 1'b1, 8'h20);
    end
    y_ready = 1; settle(); chk_y("f_d1_0", 1'b1, 8'h20);
    tick();
    chk("f_d1_cnt", 32'(dut.cnt_reg), 32'd1);
    d1 = 8'h21; last1 = 1; settle(); chk_y("f_d1_1", 1'b1, 8'h21);
    tick();
    chk_grant("f_resume", 1'b1, 1'b0, 1'b0);
    chk("f_resume_ptr", 32'(dut.ptr_reg), 32'd0);
    chk("f_resume_cnt", 32'(dut.cnt_reg), 32'd0);
    req1 = 0; last1 = 0; settle(); chk_y("f_d0_4", 1'b1, 8'h14);
    tick();
    d0 = 8'h15; last0 = 1; settle(); chk_y("f_d0_5", 1'b1, 8'h15);
    tick();
    chk_grant("f_end", 1'b0, 1'b0, 1'b0);
    req0 = 0; last0 = 0; settle(); chk_y("f_end", 1'b0, 8'h00);

    // Abandon: requester 0 drops mid-packet while requester 1 waits.
    req0 = 1; d0 = 8'h30; settle();
    tick();
    chk_grant("a_g0", 1'b1, 1'b0, 1'b0);
    settle(); chk_y("a_b0", 1'b1, 8'h30);
    tick();
    req0 = 0; req1 = 1; d1 = 8'h40; last1 = 1; settle();
    chk_y("a_drop", 1'b0, 8'h00);
    tick();
    chk_grant("a_g1", 1'b0, 1'b1, 1'b1);
    chk("a_g1_cnt", 32'(dut.cnt_reg), 32'd0);
    settle(); chk_y("a_k0", 1'b1, 8'h40);
    tick();
    chk_grant("a_end", 1'b0, 1'b0, 1'b0);
    chk("a_end_ptr", 32'(dut.ptr_reg), 32'd0);
    req1 = 0; last1 = 0; settle(); chk_y("a_end", 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
